// File: rtl/rr_sel_sched.sv
// rr_sel_sched
// Round-robin select scheduler feeding the 2-bit select of a 4:1 mux.
// Four request lines are arbitrated fairly. The winner is held on sel for
// DWELL cycles, and a one-cycle GAP follows each grant so the mux output
// settles before the next channel is announced.
//
// Parameters
//   DWELL  cycles each grant is held (1..255)
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     enables the start of new grants
//   req    per-channel request, bit i requests mux input i
//   sel    registered mux select, holds the last granted index
//   grant  registered one-hot active grant, zero when no grant is active
//   busy   high while a grant is being held
//   done   one-cycle pulse in the GAP cycle after a dwell completes normally
module rr_sel_sched #(
   parameter int unsigned DWELL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic [1:0] sel,
   output logic [3:0] grant,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DWELL = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

   state_t     state, state_nx;
   logic [1:0] ptr, ptr_nx;
   logic [7:0] cnt, cnt_nx;
   logic [1:0] sel_nx;
   logic [3:0] grant_nx;
   logic       busy_nx;
   logic       done_nx;
   logic [1:0] win;
   logic       arb;

   // Search ptr+1, ptr+2, ptr+3, ptr; the nearest set bit wins. Walking from
   // the farthest candidate inward lets the nearest one overwrite the result.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] w;
      logic [1:0] idx;
      w = p;
      for (int k = 4; k >= 1; k--) begin
         idx = p + 2'(k);
         if (r[idx]) w = idx;
      end
      return w;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   assign win = rr_pick(req, ptr);
   assign arb = en && (|req);

   // Next-state and next-output decode
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      sel_nx   = sel;
      grant_nx = grant;
      busy_nx  = busy;
      done_nx  = 1'b0;
      case (state)
         S_IDLE, S_GAP: begin
            grant_nx = 4'b0000;
            busy_nx  = 1'b0;
            if (arb) begin
               state_nx = S_DWELL;
               sel_nx   = win;
               grant_nx = onehot(win);
               busy_nx  = 1'b1;
               cnt_nx   = CNT_LOAD;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_DWELL: begin
            // Losing the request wins over a normal end on the same edge.
            if (!req[sel]) begin
               state_nx = S_GAP;
               grant_nx = 4'b0000;
               busy_nx  = 1'b0;
               ptr_nx   = sel;
            end else if (cnt == 8'd0) begin
               state_nx = S_GAP;
               grant_nx = 4'b0000;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               ptr_nx   = sel;
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end
         default: begin
            state_nx = S_IDLE;
            grant_nx = 4'b0000;
            busy_nx  = 1'b0;
         end
      endcase
   end

   // Registered state and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ptr   <= 2'd3;
         cnt   <= 8'd0;
         sel   <= 2'd0;
         grant <= 4'b0000;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         cnt   <= cnt_nx;
         sel   <= sel_nx;
         grant <= grant_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

endmodule

// File: tb/tb_rr_sel_sched.sv
module tb_rr_sel_sched;

   logic       clk = 1'b0;
   logic       rst_n, en;
   logic [3:0] req;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       busy, done;

   logic       rst1_n, en1;
   logic [3:0] req1;
   logic [1:0] sel1;
   logic [3:0] grant1;
   logic       busy1, done1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rr_sel_sched #(.DWELL(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .sel(sel), .grant(grant), .busy(busy), .done(done)
   );

   rr_sel_sched #(.DWELL(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .en(en1), .req(req1),
      .sel(sel1), .grant(grant1), .busy(busy1), .done(done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [1:0] s, input logic [3:0] g,
                             input logic b, input logic d);
      chk({tag, ".sel"},   32'(sel),   32'(s));
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".busy"},  32'(busy),  32'(b));
      chk({tag, ".done"},  32'(done),  32'(d));
   endtask

   task automatic expect_out1(input string tag, input logic [1:0] s, input logic [3:0] g,
                              input logic b, input logic d);
      chk({tag, ".sel"},   32'(sel1),   32'(s));
      chk({tag, ".grant"}, 32'(grant1), 32'(g));
      chk({tag, ".busy"},  32'(busy1),  32'(b));
      chk({tag, ".done"},  32'(done1),  32'(d));
   endtask

   // One full normal grant of channel ch (4 dwell cycles) followed by its GAP.
   task automatic run_grant(input string tag, input logic [1:0] ch);
      logic [3:0] oh;
      oh = 4'b0001 << ch;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_out({tag, ".dwell"}, ch, oh, 1'b1, 1'b0);
      end
      tick();
      expect_out({tag, ".gap"}, ch, 4'b0000, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b1;
      req    = 4'b1111;
      rst1_n = 1'b0;
      en1    = 1'b1;
      req1   = 4'b0001;

      // Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("rst", 2'd0, 4'b0000, 1'b0, 1'b0);
      end
      rst_n = 1'b1;

      // Round-robin order with all requests set
      run_grant("rr0", 2'd0);
      run_grant("rr1", 2'd1);
      run_grant("rr2", 2'd2);
      run_grant("rr3", 2'd3);
      run_grant("rr4", 2'd0);

      // Reset mid-dwell: grant drops at once with no done pulse
      tick();
      expect_out("rr5", 2'd1, 4'b0010, 1'b1, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      expect_out("rstmid", 2'd0, 4'b0000, 1'b0, 1'b0);

      // Skipping idle channels
      req = 4'b1010;
      tick();
      rst_n = 1'b1;
      run_grant("skip0", 2'd1);
      run_grant("skip1", 2'd3);
      run_grant("skip2", 2'd1);
      run_grant("skip3", 2'd3);

      // Early release of channel 2 in dwell cycle 2
      rst_n = 1'b0;
      #1;
      req = 4'b0100;
      tick();
      rst_n = 1'b1;
      tick();
      expect_out("er.d1", 2'd2, 4'b0100, 1'b1, 1'b0);
      tick();
      expect_out("er.d2", 2'd2, 4'b0100, 1'b1, 1'b0);
      req = 4'b1011;
      tick();
      expect_out("er.gap", 2'd2, 4'b0000, 1'b0, 1'b0);
      tick();
      expect_out("er.next", 2'd3, 4'b1000, 1'b1, 1'b0);

      // en drop mid-dwell: current grant completes, then idle
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("en.dwell", 2'd3, 4'b1000, 1'b1, 1'b0);
      end
      tick();
      expect_out("en.gap", 2'd3, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("en.idle", 2'd3, 4'b0000, 1'b0, 1'b0);
      end

      // DWELL=1 build
      expect_out1("d1.rst", 2'd0, 4'b0000, 1'b0, 1'b0);
      rst1_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_out1("d1.on", 2'd0, 4'b0001, 1'b1, 1'b0);
         tick();
         expect_out1("d1.off", 2'd0, 4'b0000, 1'b0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
